updown_mod_counter: RTL and testbench

//  Parametrised up/down modulo counter: runtime-programmable terminal value, sync load/clear, enable,

---
 rtl/updown_mod_counter_pkg.sv | 17 +
 rtl/updown_mod_counter_prescaler.sv | 43 ++++
 rtl/updown_mod_counter.sv | 124 ++++++++++++
 tb/tb_updown_mod_counter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/updown_mod_counter_pkg.sv
// Shared constants and types for the up/down modulo counter.
// Direction encoding and the step decision classes used by the counter datapath.
package updown_mod_counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef enum logic [2:0] {
        STEP_HOLD    = 3'd0,
        STEP_INC     = 3'd1,
        STEP_DEC     = 3'd2,
        STEP_WRAP_UP = 3'd3,
        STEP_WRAP_DN = 3'd4,
        STEP_CLAMP   = 3'd5
    } step_kind_e;

endpackage

// File: rtl/updown_mod_counter_prescaler.sv
// Enable-gated prescaler: asserts step_tick on every PRESC-th enabled cycle.
// With PRESC == 1 it collapses to a wire (step_tick = en).
module cnt_prescaler #(
    parameter int PRESC = 1
) (
    input  logic Clock,
    input  logic Reset_n,
    input  logic en,
    input  logic sclr,
    output logic step_tick
);

    generate
        if (PRESC <= 1) begin : g_bypass
            logic w_unused;
            assign w_unused  = ^{Clock, Reset_n, sclr};
            assign step_tick = en;
        end else begin : g_div
            localparam int              PW   = $clog2(PRESC);
            localparam logic [PW-1:0]   LAST = PW'(PRESC - 1);

            logic [PW-1:0] r_presc;

            // Phase only advances on enabled cycles, so en=0 freezes it mid-period.
            always_ff @(posedge Clock or negedge Reset_n) begin
                if (!Reset_n) begin
                    r_presc <= '0;
                end else if (sclr) begin
                    r_presc <= '0;
                end else if (en) begin
                    if (r_presc == LAST) begin
                        r_presc <= '0;
                    end else begin
                        r_presc <= r_presc + PW'(1);
                    end
                end
            end

            assign step_tick = en & (r_presc == LAST);
        end
    endgenerate

endmodule

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with programmable terminal value, sync clear/load,
// prescaled stepping, registered wrap pulses and a saturating wrap event counter.
module updown_mod_counter
    import updown_mod_counter_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int PRESC      = 1,
    parameter int WRAP_CNT_W = 8
) (
    input  logic                  Clock,
    input  logic                  Reset_n,
    input  logic                  en,
    input  logic                  clr,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic                  dir,
    input  logic [WIDTH-1:0]      mod_max,
    output logic [WIDTH-1:0]      q,
    output logic                  rollover,
    output logic                  underflow,
    output logic                  tc,
    output logic [WRAP_CNT_W-1:0] wrap_cnt
);

    localparam logic [WRAP_CNT_W-1:0] WRAP_MAX = '1;

    logic [WIDTH-1:0]      r_q;
    logic                  r_rollover;
    logic                  r_underflow;
    logic [WRAP_CNT_W-1:0] r_wrap_cnt;

    logic                  w_step_tick;
    logic                  w_sclr;
    logic                  w_terminal;
    logic                  w_wrap_event;
    logic [WIDTH-1:0]      w_q_next;
    logic [WIDTH-1:0]      w_load_clamped;
    step_kind_e            w_step_kind;

    assign w_sclr = clr | load;

    cnt_prescaler #(
        .PRESC (PRESC)
    ) u_prescaler (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .en        (en),
        .sclr      (w_sclr),
        .step_tick (w_step_tick)
    );

    // Wrap is decided by magnitude compare against mod_max, never by carry,
    // so a runtime-lowered mod_max below q still wraps/clamps correctly.
    always_comb begin
        w_step_kind = STEP_HOLD;
        if (w_step_tick) begin
            if (dir == DIR_UP) begin
                if (r_q >= mod_max) begin
                    w_step_kind = STEP_WRAP_UP;
                end else begin
                    w_step_kind = STEP_INC;
                end
            end else begin
                if (r_q == '0) begin
                    w_step_kind = STEP_WRAP_DN;
                end else if (r_q > mod_max) begin
                    w_step_kind = STEP_CLAMP;
                end else begin
                    w_step_kind = STEP_DEC;
                end
            end
        end
    end

    always_comb begin
        w_q_next = r_q;
        case (w_step_kind)
            STEP_INC:     w_q_next = r_q + WIDTH'(1);
            STEP_DEC:     w_q_next = r_q - WIDTH'(1);
            STEP_WRAP_UP: w_q_next = '0;
            STEP_WRAP_DN: w_q_next = mod_max;
            STEP_CLAMP:   w_q_next = mod_max;
            default:      w_q_next = r_q;
        endcase
    end

    assign w_wrap_event   = (w_step_kind == STEP_WRAP_UP) || (w_step_kind == STEP_WRAP_DN);
    assign w_load_clamped = (load_val > mod_max) ? mod_max : load_val;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            r_q         <= '0;
            r_rollover  <= 1'b0;
            r_underflow <= 1'b0;
            r_wrap_cnt  <= '0;
        end else if (clr) begin
            r_q         <= '0;
            r_rollover  <= 1'b0;
            r_underflow <= 1'b0;
            r_wrap_cnt  <= '0;
        end else if (load) begin
            r_q         <= w_load_clamped;
            r_rollover  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_q         <= w_q_next;
            r_rollover  <= (w_step_kind == STEP_WRAP_UP);
            r_underflow <= (w_step_kind == STEP_WRAP_DN);
            if (w_wrap_event && (r_wrap_cnt != WRAP_MAX)) begin
                r_wrap_cnt <= r_wrap_cnt + WRAP_CNT_W'(1);
            end
        end
    end

    // tc is combinational so a downstream stage can use it as its enable this cycle.
    assign w_terminal = (dir == DIR_UP) ? (r_q >= mod_max) : (r_q == '0);
    assign tc         = en & w_step_tick & w_terminal;

    assign q         = r_q;
    assign rollover  = r_rollover;
    assign underflow = r_underflow;
    assign wrap_cnt  = r_wrap_cnt;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed bench for updown_mod_counter: three instances cover PRESC=1, PRESC=4
// and a 2-bit wrap counter; vector table plus hand-written multi-cycle sequences.
module tb_updown_mod_counter;

    localparam int W = 16;

    logic         Clock   = 1'b0;
    logic         Reset_n = 1'b0;
    logic         en      = 1'b0;
    logic         clr     = 1'b0;
    logic         load    = 1'b0;
    logic         dir     = 1'b1;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] mod_max  = '0;

    logic [W-1:0] q_a, q_p, q_w;
    logic         ro_a, ro_p, ro_w;
    logic         un_a, un_p, un_w;
    logic         tc_a, tc_p, tc_w;
    logic [7:0]   wc_a, wc_p;
    logic [1:0]   wc_w;

    int n_cmp = 0;
    int n_err = 0;

    always #5 Clock = ~Clock;

    updown_mod_counter #(.WIDTH(W), .PRESC(1), .WRAP_CNT_W(8)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .en(en), .clr(clr), .load(load),
        .load_val(load_val), .dir(dir), .mod_max(mod_max),
        .q(q_a), .rollover(ro_a), .underflow(un_a), .tc(tc_a), .wrap_cnt(wc_a)
    );

    updown_mod_counter #(.WIDTH(W), .PRESC(4), .WRAP_CNT_W(8)) dut_p (
        .Clock(Clock), .Reset_n(Reset_n), .en(en), .clr(clr), .load(load),
        .load_val(load_val), .dir(dir), .mod_max(mod_max),
        .q(q_p), .rollover(ro_p), .underflow(un_p), .tc(tc_p), .wrap_cnt(wc_p)
    );

    updown_mod_counter #(.WIDTH(W), .PRESC(1), .WRAP_CNT_W(2)) dut_w (
        .Clock(Clock), .Reset_n(Reset_n), .en(en), .clr(clr), .load(load),
        .load_val(load_val), .dir(dir), .mod_max(mod_max),
        .q(q_w), .rollover(ro_w), .underflow(un_w), .tc(tc_w), .wrap_cnt(wc_w)
    );

    typedef struct packed {
        logic        en;
        logic        clr;
        logic        load;
        logic        dir;
        logic [15:0] lv;
        logic [15:0] mm;
        logic [15:0] q;
        logic        tc;
        logic        ro;
        logic        un;
        logic [7:0]  wc;
    } vec_t;

    vec_t vec [18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clock);
        #2;
    endtask

    initial begin
        int          sweep_bad;
        int          rp;
        logic [15:0] rq;
        logic        rro;
        logic        en_b;

        //            en clr ld dir lv        mm        q         tc ro un wc
        vec[0]  = '{1'b1,1'b0,1'b1,1'b1,16'd20,  16'd15,  16'd15,  1'b0,1'b0,1'b0,8'd0};
        vec[1]  = '{1'b1,1'b0,1'b0,1'b1,16'd0,   16'd15,  16'd0,   1'b1,1'b1,1'b0,8'd1};
        vec[2]  = '{1'b1,1'b0,1'b0,1'b0,16'd0,   16'd15,  16'd15,  1'b1,1'b0,1'b1,8'd2};
        vec[3]  = '{1'b1,1'b0,1'b0,1'b0,16'd0,   16'd15,  16'd14,  1'b0,1'b0,1'b0,8'd2};
        vec[4]  = '{1'b0,1'b0,1'b0,1'b0,16'd0,   16'd15,  16'd14,  1'b0,1'b0,1'b0,8'd2};
        vec[5]  = '{1'b1,1'b0,1'b1,1'b1,16'd12,  16'd15,  16'd12,  1'b0,1'b0,1'b0,8'd2};
        vec[6]  = '{1'b1,1'b0,1'b0,1'b1,16'd0,   16'd5,   16'd0,   1'b1,1'b1,1'b0,8'd3};
        vec[7]  = '{1'b0,1'b0,1'b1,1'b1,16'd12,  16'd15,  16'd12,  1'b0,1'b0,1'b0,8'd3};
        vec[8]  = '{1'b1,1'b0,1'b0,1'b0,16'd0,   16'd5,   16'd5,   1'b0,1'b0,1'b0,8'd3};
        vec[9]  = '{1'b1,1'b1,1'b1,1'b0,16'd3,   16'd5,   16'd0,   1'b0,1'b0,1'b0,8'd0};
        vec[10] = '{1'b1,1'b0,1'b0,1'b1,16'd0,   16'd0,   16'd0,   1'b1,1'b1,1'b0,8'd1};
        vec[11] = '{1'b1,1'b0,1'b0,1'b1,16'd0,   16'd0,   16'd0,   1'b1,1'b1,1'b0,8'd2};
        vec[12] = '{1'b1,1'b0,1'b0,1'b0,16'd0,   16'd0,   16'd0,   1'b1,1'b0,1'b1,8'd3};
        vec[13] = '{1'b1,1'b0,1'b1,1'b1,16'hFFFF,16'hFFFF,16'hFFFF,1'b0,1'b0,1'b0,8'd3};
        vec[14] = '{1'b1,1'b0,1'b0,1'b1,16'd0,   16'hFFFF,16'd0,   1'b1,1'b1,1'b0,8'd4};
        vec[15] = '{1'b1,1'b0,1'b0,1'b0,16'd0,   16'hFFFF,16'hFFFF,1'b1,1'b0,1'b1,8'd5};
        vec[16] = '{1'b1,1'b0,1'b0,1'b1,16'd0,   16'hFFFF,16'd0,   1'b1,1'b1,1'b0,8'd6};
        vec[17] = '{1'b1,1'b1,1'b0,1'b1,16'd0,   16'hFFFF,16'd0,   1'b0,1'b0,1'b0,8'd0};

        // Reset state while Reset_n is still low
        #3;
        chk("rst_q",   q_a,  0);
        chk("rst_ro",  ro_a, 0);
        chk("rst_un",  un_a, 0);
        chk("rst_wc",  wc_a, 0);
        chk("rst_tc",  tc_a, 0);
        chk("rst_q_p", q_p,  0);
        #4;
        Reset_n = 1'b1;

        // Full-range up sweep 0..FFFF then wrap
        en = 1'b1; dir = 1'b1; mod_max = 16'hFFFF;
        sweep_bad = 0;
        for (int i = 1; i <= 65535; i++) begin
            cyc();
            if (q_a !== 16'(i) || ro_a !== 1'b0) sweep_bad++;
        end
        chk("sweep_errs", sweep_bad, 0);
        chk("sweep_top_q", q_a, 16'hFFFF);
        chk("sweep_top_tc", tc_a, 1);
        cyc();
        chk("sweep_wrap_q", q_a, 0);
        chk("sweep_wrap_ro", ro_a, 1);
        chk("sweep_wrap_wc", wc_a, 1);
        cyc();
        chk("sweep_after_q", q_a, 1);
        chk("sweep_after_ro", ro_a, 0);
        en = 1'b0; clr = 1'b1;
        cyc();
        clr = 1'b0;

        // Vector table on the PRESC=1 instance
        for (int i = 0; i < 18; i++) begin
            en = vec[i].en; clr = vec[i].clr; load = vec[i].load; dir = vec[i].dir;
            load_val = vec[i].lv; mod_max = vec[i].mm;
            #1;
            chk($sformatf("v%0d_tc", i), tc_a, vec[i].tc);
            cyc();
            chk($sformatf("v%0d_q", i),  q_a,  vec[i].q);
            chk($sformatf("v%0d_ro", i), ro_a, vec[i].ro);
            chk($sformatf("v%0d_un", i), un_a, vec[i].un);
            chk($sformatf("v%0d_wc", i), wc_a, vec[i].wc);
        end
        clr = 1'b0; load = 1'b0;

        // Down count 9..0 with underflow on the wrap
        en = 1'b1; dir = 1'b0; mod_max = 16'd9;
        #1;
        chk("dn_tc_at0", tc_a, 1);
        cyc();
        chk("dn_wrap_q", q_a, 9);
        chk("dn_wrap_un", un_a, 1);
        chk("dn_wrap_wc", wc_a, 1);
        for (int k = 8; k >= 0; k--) begin
            cyc();
            chk($sformatf("dn_q%0d", k), q_a, k);
            chk($sformatf("dn_un%0d", k), un_a, 0);
        end
        chk("dn_tc_end", tc_a, 1);
        chk("dn_wc_end", wc_a, 1);
        en = 1'b0; clr = 1'b1;
        cyc();
        clr = 1'b0;

        // PRESC=4 instance: en gap holds phase, load restarts it
        dir = 1'b1; mod_max = 16'd3; load_val = 16'd9;
        rp = 0; rq = '0; rro = 1'b0;
        for (int c = 0; c < 24; c++) begin
            en_b = !(c >= 6 && c <= 10);
            en = en_b;
            load = (c == 17);
            #1;
            chk($sformatf("p_tc%0d", c), tc_p, (en_b && rp == 3 && rq >= 3) ? 1 : 0);
            cyc();
            rro = 1'b0;
            if (c == 17) begin
                rq = 16'd3;
                rp = 0;
            end else if (en_b) begin
                if (rp == 3) begin
                    rp = 0;
                    if (rq >= 3) begin
                        rq = '0;
                        rro = 1'b1;
                    end else begin
                        rq = rq + 16'd1;
                    end
                end else begin
                    rp++;
                end
            end
            chk($sformatf("p_q%0d", c), q_p, rq);
            chk($sformatf("p_ro%0d", c), ro_p, rro);
        end
        load = 1'b0; en = 1'b0; clr = 1'b1;
        cyc();
        clr = 1'b0;

        // Saturation of a 2-bit wrap counter over 5 wraps
        en = 1'b1; dir = 1'b1; mod_max = 16'd0;
        for (int k = 1; k <= 5; k++) begin
            cyc();
            chk($sformatf("sat_wcw%0d", k), wc_w, (k > 3) ? 3 : k);
            chk($sformatf("sat_wca%0d", k), wc_a, k);
        end

        // Asynchronous reset between edges
        en = 1'b0; load = 1'b1; load_val = 16'd7; mod_max = 16'd15;
        cyc();
        load = 1'b0;
        chk("pre_rst_q", q_a, 7);
        chk("pre_rst_wcw", wc_w, 3);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("arst_q", q_a, 0);
        chk("arst_wc", wc_a, 0);
        chk("arst_wcw", wc_w, 0);
        en = 1'b1; dir = 1'b0;
        #1;
        chk("arst_tc_a", tc_a, 1);
        chk("arst_tc_p", tc_p, 0);
        cyc();
        chk("arst_hold_q", q_a, 0);
        chk("arst_hold_un", un_a, 0);
        Reset_n = 1'b1;
        dir = 1'b1; mod_max = 16'd0;
        cyc();
        chk("pulse_ro", ro_a, 1);
        chk("pulse_wc", wc_a, 1);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("arst_ro", ro_a, 0);
        chk("arst_wc2", wc_a, 0);
        #2;
        Reset_n = 1'b1;
        en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
